gf128_reduce_seq: RTL and testbench

GF128_REDUCE_SEQ -- requirements
Module: gf128_reduce_seq

---
 rtl/gf_pkg.sv | 19 +
 rtl/gf128_reduce_seq_if.sv | 27 ++
 rtl/gf128_fold_step.sv | 34 +++
 rtl/gf128_reduce_seq.sv | 97 +++++++++
 tb/tb_gf128_reduce_seq.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/gf_pkg.sv
// rtl/gf_pkg.sv - shared constants, state encoding and helpers for the GF(2^128) reducer
package gf_pkg;

    localparam int           GF_M         = 128;
    localparam int           PROD_W       = 256;
    localparam logic [7:0]   POLY_LOW_DEF = 8'h87;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FOLD = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of fold cycles needed to clear the upper half for a given window width.
    function automatic int fold_count(input int step);
        return GF_M / step;
    endfunction

endpackage

// File: rtl/gf128_reduce_seq_if.sv
// rtl/gf128_reduce_seq_if.sv - product-in / remainder-out bus of the GF(2^128) reducer
interface gf128_reduce_seq_if;
    import gf_pkg::*;

    logic [PROD_W-1:0] C_In;
    logic              In_Valid;
    logic              Out_Busy;
    logic              Done;
    logic [GF_M-1:0]   R_Out;

    modport master (
        output C_In,
        output In_Valid,
        input  Out_Busy,
        input  Done,
        input  R_Out
    );

    modport slave (
        input  C_In,
        input  In_Valid,
        output Out_Busy,
        output Done,
        output R_Out
    );

endinterface

// File: rtl/gf128_fold_step.sv
// rtl/gf128_fold_step.sv - one STEP-bit fold of the 256-bit work register
module gf128_fold_step
    import gf_pkg::*;
#(
    parameter int         STEP     = 8,
    parameter logic [7:0] POLY_LOW = POLY_LOW_DEF
) (
    input  logic [PROD_W-1:0] w_i,
    input  logic [7:0]        k_i,
    output logic [PROD_W-1:0] w_o
);

    localparam logic [PROD_W-1:0] POLY_EXT = {{(PROD_W-8){1'b0}}, POLY_LOW};

    logic [PROD_W-1:0] w_v;
    int                hi;
    int                lo;

    // Walk the current window from its top bit down; each set bit x^j is replaced by
    // x^(j-128) * POLY_LOW, which always lands below the window for STEP <= 121.
    always_comb begin
        w_v = w_i;
        hi  = (PROD_W - 1) - int'(k_i) * STEP;
        lo  = hi - STEP + 1;
        for (int j = PROD_W - 1; j >= GF_M; j--) begin
            if (j <= hi && j >= lo && w_v[j]) begin
                w_v[j] = 1'b0;
                w_v    = w_v ^ (POLY_EXT << (j - GF_M));
            end
        end
        w_o = w_v;
    end

endmodule

// File: rtl/gf128_reduce_seq.sv
// rtl/gf128_reduce_seq.sv - sequential GF(2^128) reduction; GF128_RED_FASTPATH_EN skips folding for zero upper halves
module gf128_reduce_seq
    import gf_pkg::*;
#(
    parameter int         STEP     = 8,
    parameter logic [7:0] POLY_LOW = POLY_LOW_DEF
) (
    input  logic               clk,
    input  logic               rst,
    gf128_reduce_seq_if.slave  bus
);

    localparam int         N      = fold_count(STEP);
    localparam logic [7:0] K_LAST = 8'(N - 1);

    // Reject window widths that do not tile the upper half or exceed the supported range.
    generate
        if (STEP < 1 || STEP > 64 || (GF_M % STEP) != 0) begin : g_bad_step
            $error("gf128_reduce_seq: STEP must divide 128 and be in 1..64");
        end
    endgenerate

    state_t            state_q, state_d;
    logic [7:0]        k_q, k_d;
    logic [PROD_W-1:0] w_q, w_d;
    logic [GF_M-1:0]   r_q, r_d;
    logic [PROD_W-1:0] w_fold;

    gf128_fold_step #(
        .STEP     (STEP),
        .POLY_LOW (POLY_LOW)
    ) u_fold (
        .w_i (w_q),
        .k_i (k_q),
        .w_o (w_fold)
    );

    // State, counter, work register and result register; reset clears everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            w_q     <= '0;
            r_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            w_q     <= w_d;
            r_q     <= r_d;
        end
    end

    // Next-state logic: capture in IDLE, fold one window per cycle, publish on entry to DONE.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        w_d     = w_q;
        r_d     = r_q;
        unique case (state_q)
            IDLE: begin
                if (bus.In_Valid) begin
                    w_d = bus.C_In;
                    k_d = '0;
`ifdef GF128_RED_FASTPATH_EN
                    if (bus.C_In[PROD_W-1:GF_M] == '0) begin
                        state_d = DONE;
                        r_d     = bus.C_In[GF_M-1:0];
                    end else begin
                        state_d = FOLD;
                    end
`else
                    state_d = FOLD;
`endif
                end
            end
            FOLD: begin
                w_d = w_fold;
                k_d = k_q + 8'd1;
                if (k_q == K_LAST) begin
                    state_d = DONE;
                    r_d     = w_fold[GF_M-1:0];
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.Out_Busy = (state_q != IDLE);
    assign bus.Done     = (state_q == DONE);
    assign bus.R_Out    = r_q;

endmodule

// File: tb/tb_gf128_reduce_seq.sv
// tb/tb_gf128_reduce_seq.sv - directed and random checks of gf128_reduce_seq at STEP 8, 1 and 64
module tb_gf128_reduce_seq;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [255:0] c_in = '0;
    logic         in_valid = 1'b0;
    logic         rand_on = 1'b0;

    int n_vec  = 0;
    int n_miss = 0;
    int n_ops [3];

    logic         main_done;
    logic         main_busy;
    logic [127:0] main_r;

`ifdef GF128_RED_FASTPATH_EN
    localparam int LAT_ZERO = 1;
`else
    localparam int LAT_ZERO = 17;
`endif
    localparam int LAT_FULL = 17;

    localparam logic [255:0] ONE = 256'd1;

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] ref_reduce(input logic [255:0] c);
        logic [255:0] v;
        v = c;
        for (int j = 255; j >= 128; j--) begin
            if (v[j]) begin
                v[j] = 1'b0;
                v    = v ^ (256'h87 << (j - 128));
            end
        end
        return v[127:0];
    endfunction

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_inst
            localparam int SV = (g == 0) ? 8 : ((g == 1) ? 1 : 64);
            gf128_reduce_seq_if bus ();
            logic [255:0] pend;
            logic         have_pend;

            assign bus.C_In     = c_in;
            assign bus.In_Valid = in_valid;

            gf128_reduce_seq #(.STEP(SV)) u_dut (
                .clk (clk),
                .rst (rst),
                .bus (bus)
            );

            if (g == 0) begin : g_main
                assign main_done = bus.Done;
                assign main_busy = bus.Out_Busy;
                assign main_r    = bus.R_Out;
            end

            initial begin
                have_pend = 1'b0;
                pend      = '0;
                n_ops[g]  = 0;
            end

            always @(negedge clk) begin
                if (rand_on) begin
                    if (bus.Done) begin
                        if (have_pend)
                            check_val($sformatf("rand_step%0d", SV), 256'(bus.R_Out), 256'(ref_reduce(pend)));
                        else
                            check_val($sformatf("done_without_accept_step%0d", SV), 256'(bus.Done), 256'd0);
                        have_pend = 1'b0;
                        n_ops[g]  = n_ops[g] + 1;
                    end
                    if (in_valid && !bus.Out_Busy && !rst) begin
                        pend      = c_in;
                        have_pend = 1'b1;
                    end
                end
            end
        end
    endgenerate

    task automatic run_op(input logic [255:0] c, input bit inject,
                          output logic [127:0] r, output int lat, output logic busy_mid);
        int w;
        w = 0;
        @(negedge clk);
        while (main_busy && w < 300) begin
            @(negedge clk);
            w++;
        end
        c_in     = c;
        in_valid = 1'b1;
        @(posedge clk);
        lat      = 0;
        r        = '0;
        busy_mid = 1'b0;
        while (1) begin
            @(negedge clk);
            in_valid = 1'b0;
            lat++;
            if (lat == 2) busy_mid = main_busy;
            if (main_done) begin
                r = main_r;
                break;
            end
            if (inject && lat == 3) begin
                c_in     = {1'b0, {255{1'b1}}};
                in_valid = 1'b1;
            end
            if (lat >= 300) begin
                check_val("op_timeout", 256'(lat), 256'd0);
                break;
            end
        end
    endtask

    function automatic logic [255:0] rand_prod();
        logic [255:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        t[255] = 1'b0;
        return t;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] r;
        int           lat;
        logic         bm;
        logic         done_seen;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("reset_done", 256'(main_done), 256'd0);
        check_val("reset_busy", 256'(main_busy), 256'd0);
        check_val("reset_rout", 256'(main_r), 256'd0);
        rst = 1'b0;

        run_op(256'd0, 1'b0, r, lat, bm);
        check_val("zero_rout", 256'(r), 256'd0);
        check_val("zero_latency", 256'(lat), 256'(LAT_ZERO));

        run_op(ONE << 128, 1'b1, r, lat, bm);
        check_val("x128_rout", 256'(r), 256'h87);
        check_val("x128_latency", 256'(lat), 256'(LAT_FULL));
        check_val("x128_busy_mid", 256'(bm), 256'd1);

        in_valid = 1'b1;
        c_in     = ONE << 200;
        @(negedge clk);
        check_val("no_accept_in_done", 256'(main_busy), 256'd0);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rout_hold", 256'(main_r), 256'h87);

        run_op(ONE << 254, 1'b0, r, lat, bm);
        check_val("x254_rout", 256'(r), 256'hC0000000_00000000_00000000_00001067);

        run_op((ONE << 128) | ONE, 1'b0, r, lat, bm);
        check_val("x128p1_rout", 256'(r), 256'h86);

        run_op(256'h1234, 1'b0, r, lat, bm);
        check_val("low_only_rout", 256'(r), 256'h1234);
        check_val("low_only_latency", 256'(lat), 256'(LAT_ZERO));

        @(negedge clk);
        c_in      = ONE << 254;
        in_valid  = 1'b1;
        @(posedge clk);
        done_seen = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (main_done) done_seen = 1'b1;
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_val("rst_mid_done", 256'(main_done), 256'd0);
        check_val("rst_mid_busy", 256'(main_busy), 256'd0);
        check_val("rst_mid_rout", 256'(main_r), 256'd0);
        check_val("rst_mid_no_pulse", 256'(done_seen), 256'd0);
        run_op(ONE << 254, 1'b0, r, lat, bm);
        check_val("after_rst_rout", 256'(r), 256'hC0000000_00000000_00000000_00001067);
        check_val("after_rst_latency", 256'(lat), 256'(LAT_FULL));

        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b0;
        c_in     = rand_prod();
        in_valid = 1'b1;
        rand_on  = 1'b1;
        repeat (6000) begin
            @(posedge clk);
            #1;
            c_in = rand_prod();
        end
        @(negedge clk);
        rand_on  = 1'b0;
        in_valid = 1'b0;
        check_val("rand_ops_step8", 256'(n_ops[0] > 0), 256'd1);
        check_val("rand_ops_step1", 256'(n_ops[1] > 0), 256'd1);
        check_val("rand_ops_step64", 256'(n_ops[2] > 0), 256'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
